simple_dds_wb_master: RTL
=========================

// Module: simple_dds_wb_master
// PURPOSE
//  Wishbone classic initiator that programs and reads back the simple_dds register file.
//  Accepts single commands (addr, data, we) on a valid/ready port and runs one Wishbone cycle per command.
//  Returns read data and a status flag on a response port.
//  Sits between a host/CPU-side controller and the simple_dds Wishbone slave port; replaces bench-driven bus access in system builds.
// PARAMETERS
//  DATA_WIDTH      32   Wishbone data width.
//  ADDR_WIDTH      16   Wishbone address width.
//  TIMEOUT_CYCLES  16   max cycles waiting for ack (used only with SIMPLE_DDS_WB_TIMEOUT_EN); must be >= 2.
// PORTS
//  wb_clk_i     in   1           single clock; all logic on rising edge.
//  wb_rst_n_i   in   1           asynchronous, active-low reset.
//  cmd_valid_i  in   1           command request.
//  cmd_ready_o  out  1           command accepted when valid && ready.
//  cmd_we_i     in   1           1 = write, 0 = read.
//  cmd_addr_i   in   ADDR_WIDTH  register address.
//  cmd_data_i   in   DATA_WIDTH  write data; ignored for reads.
//  rsp_valid_o  out  1           response available.
//  rsp_ready_i  in   1           response consumed when valid && ready.
//  rsp_data_o   out  DATA_WIDTH  read data; 0 for writes and errors.
//  rsp_err_o    out  1           1 = no ack (timeout).
//  wb_cyc_o     out  1           Wishbone cycle.
//  wb_stb_o     out  1           Wishbone strobe; identical to wb_cyc_o.
//  wb_we_o      out  1           Wishbone write enable.
//  wb_addr_o    out  ADDR_WIDTH  Wishbone address.
//  wb_dat_o     out  DATA_WIDTH  Wishbone write data.
//  wb_dat_i     in   DATA_WIDTH  Wishbone read data.
//  wb_ack_i     in   1           Wishbone acknowledge.
// BEHAVIOUR
//  Reset values:
//   - All outputs 0 except cmd_ready_o = 1.
//   - Reset acts asynchronously and drops cyc/stb immediately, including mid-cycle.
//   - Any pending response is discarded.
//  FSM states: IDLE, BUS, RESP; all outputs are registered.
//  IDLE:
//   - cmd_ready_o = 1.
//   - On valid&&ready, latch we/addr/data onto wb_*_o, set cyc=stb=1, go to BUS.
//  BUS:
//   - cmd_ready_o = 0; addr/we/dat held stable.
//   - On an edge with wb_ack_i = 1: capture wb_dat_i into rsp_data_o for reads (0 for writes), set rsp_err_o = 0, clear cyc/stb on that edge, go to RESP.
//  RESP:
//   - rsp_valid_o = 1; data/err held.
//   - On rsp_ready_i, clear rsp_valid_o and go to IDLE.
//   - No new command is accepted until the response is consumed.
//  Latency against simple_dds (registered ack, one cycle after stb sampled):
//   - Command accepted at edge N; stb high after N.
//   - Ack sampled at N+2; rsp_valid_o high after N+2.
//   - cmd_ready_o returns the cycle after the response handshake.
//   - Best-case throughput: 1 command per 4 cycles.
//  Boundaries:
//   - wb_ack_i while in IDLE or RESP: ignored.
//   - cmd_valid_i while not ready: held off, not dropped.
//   - rsp_ready_i held high permanently: RESP lasts exactly 1 cycle.
//   - Addresses are passed through unchanged; no range check.
// CONFIGURATION
//  SIMPLE_DDS_WB_TIMEOUT_EN defined:
//   - A cycle counter clears on entry to BUS and increments each BUS cycle.
//   - If TIMEOUT_CYCLES elapse with no ack: drop cyc/stb, rsp_err_o = 1, rsp_data_o = 0, go to RESP.
//   - An ack on the same edge as expiry wins; the response is normal.
//  Not defined:
//   - BUS waits indefinitely; rsp_err_o is tied 0; no counter logic is built.
// STRUCTURE
//  simple_dds_pkg (shared with simple_dds and benches):
//   - Register address constants READY=0, ENABLE=1, DDS_SRC=2, TUNING_WORD=3, GAIN_WORD=4, OFFSET_WORD=5.
//   - Register reset-value constants.
//   - FSM state encoding (IDLE, BUS, RESP).
//  Sub-module simple_dds_wb_timeout: counter with clear/enable inputs and an expired output; instantiated only under the macro.
// TESTING
//  1. Reset, then read READY from simple_dds until 1 -> rsp_data_o=32'h1, rsp_err_o=0, ack arrives 2 edges after accept.
//  2. Write TUNING_WORD 32'hFFFF_FFFF, then read it back -> rsp_data_o[15:0]=16'hFFFF; cyc/stb low after ack edge.
//  3. Back-to-back cmd_valid_i with rsp_ready_i low for 5 cycles -> cmd_ready_o stays 0 until response taken; second command is issued unchanged.
//  4. Slave stub never acks, macro defined, TIMEOUT_CYCLES=16 -> rsp_err_o=1 and rsp_data_o=0 after 16 BUS cycles; cyc/stb released.
//  5. Assert wb_rst_n_i low mid-BUS -> cyc/stb drop immediately; cmd_ready_o=1, rsp_valid_o=0 after release.
//  6. Spurious wb_ack_i pulse in IDLE -> no response, no state change.

Source files
------------

// File: rtl/simple_dds_pkg.sv
// ============================================================================
//  Module      : simple_dds_pkg
//  Description : Definitions shared by simple_dds, its Wishbone initiator and
//                the benches. Holds the register map, the register reset
//                values and the initiator FSM state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simple_dds_pkg;

    // Register map of the simple_dds Wishbone slave
    localparam logic [15:0] REG_READY       = 16'd0;
    localparam logic [15:0] REG_ENABLE      = 16'd1;
    localparam logic [15:0] REG_DDS_SRC     = 16'd2;
    localparam logic [15:0] REG_TUNING_WORD = 16'd3;
    localparam logic [15:0] REG_GAIN_WORD   = 16'd4;
    localparam logic [15:0] REG_OFFSET_WORD = 16'd5;

    // Register reset values
    localparam logic [31:0] RST_READY       = 32'h0000_0000;
    localparam logic [31:0] RST_ENABLE      = 32'h0000_0000;
    localparam logic [31:0] RST_DDS_SRC     = 32'h0000_0000;
    localparam logic [31:0] RST_TUNING_WORD = 32'h0000_0000;
    localparam logic [31:0] RST_GAIN_WORD   = 32'h0000_0000;
    localparam logic [31:0] RST_OFFSET_WORD = 32'h0000_0000;

    // Wishbone initiator FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/simple_dds_wb_master_if.sv
// ============================================================================
//  Module      : simple_dds_wb_master_if
//  Description : Bundles the command port, the response port and the Wishbone
//                classic bus of simple_dds_wb_master.
//                  master : view of the initiator itself
//                  slave  : view of the host plus Wishbone slave around it
//  Signals     : cmd_valid_i/cmd_ready_o/cmd_we_i/cmd_addr_i/cmd_data_i,
//                rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_err_o,
//                wb_cyc_o/wb_stb_o/wb_we_o/wb_addr_o/wb_dat_o/wb_dat_i/wb_ack_i
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simple_dds_wb_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    // command port
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_data_i;
    // response port
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic                  rsp_err_o;
    // Wishbone classic
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-1:0] wb_addr_o;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
               wb_dat_i, wb_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
               wb_dat_i, wb_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o
    );

endinterface

`default_nettype wire

// File: rtl/simple_dds_wb_timeout.sv
// ============================================================================
//  Module      : simple_dds_wb_timeout
//  Description : Ack-wait counter for simple_dds_wb_master. Built only when
//                SIMPLE_DDS_WB_TIMEOUT_EN is defined.
//  Ports       : clk     - clock
//                rst_n   - asynchronous active-low reset
//                clear   - restart count (bus cycle being launched)
//                enable  - count this cycle (bus cycle in progress)
//                expired - TIMEOUT_CYCLES enabled cycles have elapsed
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef SIMPLE_DDS_WB_TIMEOUT_EN
module simple_dds_wb_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire clk,
    input  wire rst_n,
    input  wire clear,
    input  wire enable,
    output wire expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Expiry flags the edge that closes the TIMEOUT_CYCLES-th bus cycle
    assign expired = enable && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

`default_nettype wire

// File: rtl/simple_dds_wb_master.sv
// ============================================================================
//  Module      : simple_dds_wb_master
//  Description : Wishbone classic initiator for the simple_dds register file.
//                Takes one (we, addr, data) command on a valid/ready port,
//                runs one Wishbone cycle for it and returns read data plus an
//                error flag on a valid/ready response port.
//                Optional ack timeout: define SIMPLE_DDS_WB_TIMEOUT_EN.
//  Ports       : wb_clk_i   - clock, rising edge
//                wb_rst_n_i - asynchronous active-low reset
//                bus        - simple_dds_wb_master_if.master (command,
//                             response and Wishbone signals)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_dds_wb_master
    import simple_dds_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire                    wb_clk_i,
    input  wire                    wb_rst_n_i,
    simple_dds_wb_master_if.master bus
);

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("simple_dds_wb_master: TIMEOUT_CYCLES must be >= 2");
        end
    endgenerate

    wb_state_t             r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_cyc;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_dat;

    wire w_accept   = r_cmd_ready && bus.cmd_valid_i;
    wire w_bus_busy = (r_state == ST_BUS);
    wire w_expired;

`ifdef SIMPLE_DDS_WB_TIMEOUT_EN
    simple_dds_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .clear   (w_accept),
        .enable  (w_bus_busy),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_dat       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.cmd_we_i;
                        r_addr      <= bus.cmd_addr_i;
                        r_dat       <= bus.cmd_data_i;
                        r_cyc       <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // A real ack takes priority over a timeout on the same edge
                    if (bus.wb_ack_i) begin
                        r_rsp_data  <= r_we ? '0 : bus.wb_dat_i;
                        r_rsp_err   <= 1'b0;
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_expired) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_cyc       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o = r_cmd_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_data_o  = r_rsp_data;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.wb_cyc_o    = r_cyc;
    assign bus.wb_stb_o    = r_cyc;
    assign bus.wb_we_o     = r_we;
    assign bus.wb_addr_o   = r_addr;
    assign bus.wb_dat_o    = r_dat;

endmodule

`default_nettype wire
